prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter: PC_W, 10, program-counter width.
REQ-002 Parameter: CNT_W, 16, cycle-counter width.
REQ-003 Parameter: MAX_CYCLES, 4000, RUN-cycle limit before timeout; SHALL satisfy 1 <= MAX_CYCLES <= 2^CNT_W-1.
REQ-004 Parameter: PROG0_ADDR/PROG1_ADDR/PROG2_ADDR/PROG3_ADDR, 0/256/512/768, per-program start PC.
REQ-005 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 req  in  1  run request from test harness (4-phase handshake).
REQ-009 prog_sel  in  2  program index, sampled with req.
REQ-010 done_in  in  1  done flag from instruction decoder.
REQ-011 start  out  1  holds decoder/PC in start state (blocks reg, mem, PC writes).
REQ-012 pc_load  out  1  one-cycle strobe: PC <= pc_init.
REQ-013 pc_init  out  PC_W  start address of selected program.
REQ-014 run  out  1  program executing.
REQ-015 busy  out  1  run in progress (LOAD or RUN).
REQ-016 ack  out  1  run finished, result stable.
REQ-017 timeout  out  1  run ended by cycle limit, not done_in.
REQ-018 cycle_count  out  CNT_W  RUN cycles of current/last run.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, FINISH; all outputs registered or decoded from state plus registers only (no combinational path from inputs to outputs).
REQ-020 IDLE: start=1, busy=0, run=0, ack=0, pc_load=0; req=1 at clock edge -> LOAD, prog_sel latched into sel_q.
REQ-021 LOAD: exactly one cycle; start=1, busy=1, pc_load=1, pc_init=PROGn_ADDR[sel_q]; cycle_count cleared to 0, timeout cleared to 0; -> RUN.
REQ-022 pc_init SHALL hold PROGn_ADDR[sel_q] in all states except after reset (0).
REQ-023 RUN: start=0, run=1, busy=1; cycle_count increments by 1 every RUN cycle, including the cycle done_in is sampled high.
REQ-024 RUN, done_in=1 -> FINISH, timeout stays 0.
REQ-025 RUN, done_in=0 and cycle_count == MAX_CYCLES-1 -> FINISH, timeout set to 1 (final cycle_count = MAX_CYCLES).
REQ-026 done_in and limit on the same cycle: done_in wins, timeout=0.
REQ-027 FINISH: start=1, ack=1, busy=0, run=0; cycle_count and timeout frozen; stays until req=0 -> IDLE.
REQ-028 ack SHALL deassert the cycle after FINISH exits; cycle_count and timeout SHALL keep their values in IDLE until the next LOAD.
REQ-029 done_in SHALL be ignored in IDLE, LOAD, FINISH.
REQ-030 req or prog_sel changes during LOAD/RUN SHALL be ignored; req held high through FINISH SHALL not start a new run (must drop to 0 first).
REQ-031 Latency: req high at edge k -> pc_load high cycle k+1 -> run high from cycle k+2.
REQ-032 cycle_count SHALL never wrap (bounded by REQ-003).

Reset
REQ-033 reset=1 SHALL immediately (asynchronously) force IDLE: start=1, pc_load=0, pc_init=0, run=0, busy=0, ack=0, timeout=0, cycle_count=0, sel_q=0.
REQ-034 reset asserted mid-RUN SHALL abort the run with no ack; first req after release starts a fresh LOAD.

Verification
REQ-035 Basic run: reset, req=1 prog_sel=2, done_in pulsed on 5th RUN cycle -> pc_load one cycle with pc_init=512, run 5 cycles, ack=1, cycle_count=5, timeout=0; req=0 -> ack=0 next cycle.
REQ-036 Timeout: MAX_CYCLES=8, prog_sel=1, done_in never -> run 8 cycles, ack=1, timeout=1, cycle_count=8, pc_init=256.
REQ-037 Collision: MAX_CYCLES=8, done_in high on 8th RUN cycle -> ack=1, timeout=0, cycle_count=8.
REQ-038 Handshake: req held high after ack for 10 cycles -> stays FINISH, no pc_load; req low then high with prog_sel=3 -> new LOAD, pc_init=768, cycle_count cleared.
REQ-039 Mid-run reset: assert reset on 3rd RUN cycle -> all outputs per REQ-033 same cycle, no ack; subsequent run with done on 1st RUN cycle -> cycle_count=1.
REQ-040 Ignore inputs: toggle prog_sel and pulse done_in during LOAD and IDLE -> pc_init unchanged, no spurious FINISH.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program run sequencer: accepts a 4-phase run request, loads the selected
// program's start PC, runs it until done_in or a cycle limit, then acknowledges.
module prog_sequencer #(
   parameter int PC_W       = 10,
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 4000,
   parameter int PROG0_ADDR = 0,
   parameter int PROG1_ADDR = 256,
   parameter int PROG2_ADDR = 512,
   parameter int PROG3_ADDR = 768
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [1:0]       prog_sel,
   input  logic             done_in,
   output logic             start,
   output logic             pc_load,
   output logic [PC_W-1:0]  pc_init,
   output logic             run,
   output logic             busy,
   output logic             ack,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

   state_t           r_state;
   state_t           w_nextState;
   logic [1:0]       r_sel;
   logic             r_loaded;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;
   logic             w_limitHit;

   function automatic logic [PC_W-1:0] progAddr(input logic [1:0] sel);
      case (sel)
         2'd0:    progAddr = PC_W'(PROG0_ADDR);
         2'd1:    progAddr = PC_W'(PROG1_ADDR);
         2'd2:    progAddr = PC_W'(PROG2_ADDR);
         default: progAddr = PC_W'(PROG3_ADDR);
      endcase
   endfunction

   assign w_limitHit = (r_cnt == LIMIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // done_in has priority over the cycle limit when both land on the same RUN cycle
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (req) w_nextState = LOAD;
         LOAD:    w_nextState = RUN;
         RUN:     if (done_in || w_limitHit) w_nextState = FINISH;
         FINISH:  if (!req) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel     <= 2'd0;
         r_loaded  <= 1'b0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req) begin
                  r_sel    <= prog_sel;
                  r_loaded <= 1'b1;
               end
            end
            LOAD: begin
               r_cnt     <= '0;
               r_timeout <= 1'b0;
            end
            RUN: begin
               r_cnt <= r_cnt + 1'b1;
               if (!done_in && w_limitHit) r_timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // pc_init reads 0 until the first run has latched a selection
   assign pc_init     = r_loaded ? progAddr(r_sel) : '0;
   assign start       = (r_state != RUN);
   assign pc_load     = (r_state == LOAD);
   assign run         = (r_state == RUN);
   assign busy        = (r_state == LOAD) || (r_state == RUN);
   assign ack         = (r_state == FINISH);
   assign timeout     = r_timeout;
   assign cycle_count = r_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a scoreboard of expected run results,
// checked with immediate assertions.
module tb_prog_sequencer;

   localparam int PC_W  = 10;
   localparam int CNT_W = 16;

   typedef struct {
      logic [CNT_W-1:0] cnt;
      logic             to;
      logic [PC_W-1:0]  pc;
      int               runCycles;
   } result_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             req;
   logic [1:0]       prog_sel;
   logic             done_in;
   logic             start;
   logic             pc_load;
   logic [PC_W-1:0]  pc_init;
   logic             run;
   logic             busy;
   logic             ack;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;

   int      vectors = 0;
   int      miscompares = 0;
   result_t sbQueue[$];

   prog_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .done_in(done_in),
      .start(start), .pc_load(pc_load), .pc_init(pc_init), .run(run), .busy(busy),
      .ack(ack), .timeout(timeout), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PC_W-1:0] addrOf(input logic [1:0] sel);
      logic [PC_W-1:0] a;
      a = PC_W'(256 * sel);
      return a;
   endfunction

   task automatic checkIdleReset(input string tag);
      checkOutput({tag, ".start"}, 32'(start), 32'd1);
      checkOutput({tag, ".pc_load"}, 32'(pc_load), 32'd0);
      checkOutput({tag, ".pc_init"}, 32'(pc_init), 32'd0);
      checkOutput({tag, ".run"}, 32'(run), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".ack"}, 32'(ack), 32'd0);
      checkOutput({tag, ".timeout"}, 32'(timeout), 32'd0);
      checkOutput({tag, ".cycle_count"}, 32'(cycle_count), 32'd0);
   endtask

   // One full run; doneAt = 0 means done_in never asserts; perturb disturbs inputs during LOAD
   task automatic applyStimulus(input string tag, input logic [1:0] sel, input int doneAt,
                                input int expCnt, input logic expTo, input bit perturb);
      result_t exp;
      result_t got;
      int      runCycles;
      exp.cnt       = CNT_W'(expCnt);
      exp.to        = expTo;
      exp.pc        = addrOf(sel);
      exp.runCycles = expCnt;
      sbQueue.push_back(exp);

      req      = 1'b1;
      prog_sel = sel;
      tick();
      checkOutput({tag, ".load.pc_load"}, 32'(pc_load), 32'd1);
      checkOutput({tag, ".load.busy"}, 32'(busy), 32'd1);
      checkOutput({tag, ".load.start"}, 32'(start), 32'd1);
      checkOutput({tag, ".load.pc_init"}, 32'(pc_init), 32'(addrOf(sel)));
      if (perturb) begin
         prog_sel = ~sel;
         done_in  = 1'b1;
         req      = 1'b0;
      end
      tick();
      done_in = 1'b0;
      req     = 1'b1;
      checkOutput({tag, ".run1.run"}, 32'(run), 32'd1);
      checkOutput({tag, ".run1.start"}, 32'(start), 32'd0);
      checkOutput({tag, ".run1.cnt"}, 32'(cycle_count), 32'd0);
      checkOutput({tag, ".run1.timeout"}, 32'(timeout), 32'd0);

      runCycles = 0;
      while (run === 1'b1 && runCycles < 20) begin
         runCycles++;
         done_in = (runCycles == doneAt);
         tick();
      end
      done_in = 1'b0;

      checkOutput({tag, ".ack"}, 32'(ack), 32'd1);
      checkOutput({tag, ".finish.busy"}, 32'(busy), 32'd0);
      if (sbQueue.size() == 0) begin
         checkOutput({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         got = sbQueue.pop_front();
         checkOutput({tag, ".runCycles"}, 32'(runCycles), 32'(got.runCycles));
         checkOutput({tag, ".cycle_count"}, 32'(cycle_count), 32'(got.cnt));
         checkOutput({tag, ".timeout"}, 32'(timeout), 32'(got.to));
         checkOutput({tag, ".pc_init"}, 32'(pc_init), 32'(got.pc));
      end
   endtask

   // Drop req, confirm ack clears next cycle while results stay frozen
   task automatic releaseReq(input string tag, input int expCnt, input logic expTo);
      req = 1'b0;
      tick();
      checkOutput({tag, ".rel.ack"}, 32'(ack), 32'd0);
      checkOutput({tag, ".rel.cnt"}, 32'(cycle_count), 32'(expCnt));
      checkOutput({tag, ".rel.timeout"}, 32'(timeout), 32'(expTo));
   endtask

   initial begin
      int loads;
      int acks;
      reset    = 1'b1;
      req      = 1'b0;
      prog_sel = 2'd0;
      done_in  = 1'b0;
      #1;
      checkIdleReset("reset");
      tick();
      reset = 1'b0;
      tick();

      applyStimulus("basic", 2'd2, 5, 5, 1'b0, 1'b0);
      releaseReq("basic", 5, 1'b0);

      applyStimulus("timeout", 2'd1, 0, 8, 1'b1, 1'b0);
      releaseReq("timeout", 8, 1'b1);

      applyStimulus("collision", 2'd0, 8, 8, 1'b0, 1'b0);
      releaseReq("collision", 8, 1'b0);

      // Hold req after ack: must stay in FINISH without reloading
      applyStimulus("hold", 2'd1, 3, 3, 1'b0, 1'b0);
      loads = 0;
      acks  = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pc_load === 1'b1) loads++;
         if (ack === 1'b1) acks++;
      end
      checkOutput("hold.no_pc_load", 32'(loads), 32'd0);
      checkOutput("hold.ack_held", 32'(acks), 32'd10);
      releaseReq("hold", 3, 1'b0);
      applyStimulus("hold.next", 2'd3, 2, 2, 1'b0, 1'b0);
      releaseReq("hold.next", 2, 1'b0);

      // Abort a run asynchronously on its 3rd RUN cycle
      req      = 1'b1;
      prog_sel = 2'd2;
      tick();
      req = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("midreset.in_run", 32'(run), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkIdleReset("midreset");
      tick();
      reset = 1'b0;
      req   = 1'b0;
      tick();
      checkOutput("midreset.no_ack", 32'(ack), 32'd0);
      applyStimulus("afterreset", 2'd1, 1, 1, 1'b0, 1'b0);
      releaseReq("afterreset", 1, 1'b0);

      // Noise on prog_sel/done_in in IDLE, then during LOAD
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         prog_sel = 2'(i);
         done_in  = i[0];
         tick();
         if (ack === 1'b1 || busy === 1'b1) acks++;
      end
      done_in = 1'b0;
      checkOutput("ignore.idle_activity", 32'(acks), 32'd0);
      checkOutput("ignore.idle_pc_init", 32'(pc_init), 32'd256);
      checkOutput("ignore.idle_cnt", 32'(cycle_count), 32'd1);
      applyStimulus("ignore.load", 2'd2, 2, 2, 1'b0, 1'b1);
      releaseReq("ignore.load", 2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
